// File: rtl/match_monitor.sv
// match_monitor
//   Registered NCH-channel equality monitor. Each accepted sample (in_valid=1,
//   clear=0) updates the result one cycle later, along with an out_valid pulse.
//   A small FSM tracks runs of equal samples. After STABLE_LEN consecutive equal
//   samples it reports stable agreement. Saturating statistics are kept for
//   board display.
//
//   Optional build macro: MATCH_MONITOR_DIFF_EN adds the diff_mask and
//   first_diff outputs.
//
//   Ports
//     clk             system clock, rising edge
//     rst_n           asynchronous active-low reset
//     clear           synchronous clear of FSM, counters and sticky flag
//     in_valid        in_data holds a sample this cycle
//     in_data         packed channels, channel i at [i*WIDTH +: WIDTH]
//     out_valid       one-cycle pulse after an accepted sample
//     equal           all channels equal in the last accepted sample
//     stable          FSM is in S_LOCK
//     lock_lost       one-cycle pulse on S_LOCK -> S_SEEK
//     streak          consecutive equal samples, saturating
//     mismatch_cnt    unequal samples since reset/clear, saturating
//     sticky_mismatch set by any unequal sample
//     diff_mask       (DIFF_EN) bit i = channel i differs from channel 0
//     first_diff      (DIFF_EN) lowest differing channel index, 0 if none
//
//   state   | meaning
//   S_IDLE  | after reset/clear, no sample seen yet
//   S_SEEK  | last sample unequal, waiting for an equal one
//   S_COUNT | counting equal samples toward STABLE_LEN
//   S_LOCK  | at least STABLE_LEN consecutive equal samples
module match_monitor #(
    parameter int WIDTH      = 7,
    parameter int NCH        = 3,
    parameter int STABLE_LEN = 4,
    parameter int CNT_W      = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear,
    input  logic                 in_valid,
    input  logic [NCH*WIDTH-1:0] in_data,
    output logic                 out_valid,
    output logic                 equal,
    output logic                 stable,
    output logic                 lock_lost,
    output logic [CNT_W-1:0]     streak,
    output logic [CNT_W-1:0]     mismatch_cnt,
    output logic                 sticky_mismatch
`ifdef MATCH_MONITOR_DIFF_EN
    ,
    output logic [NCH-1:0]           diff_mask,
    output logic [$clog2(NCH)-1:0]   first_diff
`endif
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SEEK  = 2'd1,
        S_COUNT = 2'd2,
        S_LOCK  = 2'd3
    } state_t;

    state_t state;
    state_t state_nxt;

    logic             eq;
    logic             accept;
    logic             reach;
    logic [CNT_W:0]   streak_inc;
    logic [CNT_W-1:0] streak_sat;
    logic [CNT_W-1:0] mismatch_sat;

    assign accept = in_valid && !clear;

    always_comb begin
        eq = 1'b1;
        for (int i = 1; i < NCH; i++) begin
            if (in_data[i*WIDTH +: WIDTH] != in_data[WIDTH-1:0]) begin
                eq = 1'b0;
            end
        end
    end

    // The threshold compare uses one extra bit so that a saturated streak
    // cannot wrap and appear to fall back below STABLE_LEN.
    assign streak_inc   = {1'b0, streak} + {{CNT_W{1'b0}}, 1'b1};
    assign reach        = (streak_inc >= (CNT_W+1)'(STABLE_LEN));
    assign streak_sat   = (&streak) ? streak : streak + 1'b1;
    assign mismatch_sat = (&mismatch_cnt) ? mismatch_cnt : mismatch_cnt + 1'b1;

    always_comb begin
        state_nxt = S_IDLE;
        case (state)
            S_IDLE, S_SEEK: begin
                if (eq) state_nxt = (STABLE_LEN == 1) ? S_LOCK : S_COUNT;
                else    state_nxt = S_SEEK;
            end
            S_COUNT: begin
                if (eq) state_nxt = reach ? S_LOCK : S_COUNT;
                else    state_nxt = S_SEEK;
            end
            S_LOCK: begin
                state_nxt = eq ? S_LOCK : S_SEEK;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= S_IDLE;
            out_valid       <= 1'b0;
            equal           <= 1'b0;
            stable          <= 1'b0;
            lock_lost       <= 1'b0;
            streak          <= '0;
            mismatch_cnt    <= '0;
            sticky_mismatch <= 1'b0;
        end else if (clear) begin
            state           <= S_IDLE;
            out_valid       <= 1'b0;
            equal           <= 1'b0;
            stable          <= 1'b0;
            lock_lost       <= 1'b0;
            streak          <= '0;
            mismatch_cnt    <= '0;
            sticky_mismatch <= 1'b0;
        end else if (accept) begin
            state     <= state_nxt;
            out_valid <= 1'b1;
            equal     <= eq;
            stable    <= (state_nxt == S_LOCK);
            lock_lost <= (state == S_LOCK) && !eq;
            if (eq) begin
                streak <= streak_sat;
            end else begin
                streak          <= '0;
                mismatch_cnt    <= mismatch_sat;
                sticky_mismatch <= 1'b1;
            end
        end else begin
            out_valid <= 1'b0;
            lock_lost <= 1'b0;
        end
    end

`ifdef MATCH_MONITOR_DIFF_EN
    logic [NCH-1:0]         diff_mask_c;
    logic [$clog2(NCH)-1:0] first_diff_c;

    always_comb begin
        diff_mask_c  = '0;
        first_diff_c = '0;
        for (int i = 1; i < NCH; i++) begin
            diff_mask_c[i] = (in_data[i*WIDTH +: WIDTH] != in_data[WIDTH-1:0]);
        end
        // Scan downward so the lowest differing index wins.
        for (int i = NCH - 1; i >= 1; i--) begin
            if (diff_mask_c[i]) first_diff_c = ($clog2(NCH))'(i);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            diff_mask  <= '0;
            first_diff <= '0;
        end else if (clear) begin
            diff_mask  <= '0;
            first_diff <= '0;
        end else if (accept) begin
            diff_mask  <= diff_mask_c;
            first_diff <= first_diff_c;
        end
    end
`endif

endmodule

// File: tb/tb_match_monitor.sv
module tb_match_monitor;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // dut1: default parameters (WIDTH=7, NCH=3, STABLE_LEN=4, CNT_W=8)
    logic        clear1, valid1;
    logic [20:0] data1;
    logic        ov1, eq1, st1, ll1, sk1;
    logic [7:0]  streak1, mm1;

    // dut2: NCH=4, STABLE_LEN=1, CNT_W=2
    logic        clear2, valid2;
    logic [27:0] data2;
    logic        ov2, eq2, st2, ll2, sk2;
    logic [1:0]  streak2, mm2;

`ifdef MATCH_MONITOR_DIFF_EN
    logic [2:0] dm1;
    logic [1:0] fd1;
    logic [3:0] dm2;
    logic [1:0] fd2;
`endif

    match_monitor dut1 (
        .clk(clk), .rst_n(rst_n), .clear(clear1), .in_valid(valid1), .in_data(data1),
        .out_valid(ov1), .equal(eq1), .stable(st1), .lock_lost(ll1),
        .streak(streak1), .mismatch_cnt(mm1), .sticky_mismatch(sk1)
`ifdef MATCH_MONITOR_DIFF_EN
        , .diff_mask(dm1), .first_diff(fd1)
`endif
    );

    match_monitor #(.WIDTH(7), .NCH(4), .STABLE_LEN(1), .CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .clear(clear2), .in_valid(valid2), .in_data(data2),
        .out_valid(ov2), .equal(eq2), .stable(st2), .lock_lost(ll2),
        .streak(streak2), .mismatch_cnt(mm2), .sticky_mismatch(sk2)
`ifdef MATCH_MONITOR_DIFF_EN
        , .diff_mask(dm2), .first_diff(fd2)
`endif
    );

    // {out_valid, equal, stable, lock_lost, streak, mismatch_cnt, sticky}
    logic [20:0] obs1;
    logic [8:0]  obs2;
    assign obs1 = {ov1, eq1, st1, ll1, streak1, mm1, sk1};
    assign obs2 = {ov2, eq2, st2, ll2, streak2, mm2, sk2};

    int n_vec = 0;
    int n_err = 0;

    localparam logic [20:0] EQ100  = {7'd100, 7'd100, 7'd100};
    localparam logic [20:0] NE98   = {7'd99, 7'd99, 7'd98};
    localparam logic [20:0] EQ97   = {7'd97, 7'd97, 7'd97};
    localparam logic [27:0] NE4    = {7'd0, 7'd0, 7'd0, 7'd1};
    localparam logic [27:0] EQ4    = {7'd3, 7'd3, 7'd3, 7'd3};

    task automatic drive1(input logic v, input logic c, input logic [20:0] d);
        @(negedge clk);
        valid1 = v; clear1 = c; data1 = d;
        @(posedge clk);
        #1;
    endtask

    task automatic drive2(input logic v, input logic c, input logic [27:0] d);
        @(negedge clk);
        valid2 = v; clear2 = c; data2 = d;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        valid1 = 1'b0; clear1 = 1'b0; data1 = '0;
        valid2 = 1'b0; clear2 = 1'b0; data2 = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        n_vec++;
        if (obs1 !== 21'd0) begin
            n_err++;
            $display("FAIL reset_dut1: got %h expected %h", obs1, 21'd0);
        end
        n_vec++;
        if (obs2 !== 9'd0) begin
            n_err++;
            $display("FAIL reset_dut2: got %h expected %h", obs2, 9'd0);
        end
`ifdef MATCH_MONITOR_DIFF_EN
        n_vec++;
        if ({dm2, fd2} !== 6'd0) begin
            n_err++;
            $display("FAIL reset_diff: got %h expected %h", {dm2, fd2}, 6'd0);
        end
`endif
    endtask

    task automatic test_equal_run;
        logic [20:0] exp;
        for (int k = 1; k <= 4; k++) begin
            drive1(1'b1, 1'b0, EQ100);
            exp = {1'b1, 1'b1, (k == 4), 1'b0, 8'(k), 8'd0, 1'b0};
            n_vec++;
            if (obs1 !== exp) begin
                n_err++;
                $display("FAIL equal_run_%0d: got %h expected %h", k, obs1, exp);
            end
        end
        drive1(1'b0, 1'b0, EQ100);
        exp = {1'b0, 1'b1, 1'b1, 1'b0, 8'd4, 8'd0, 1'b0};
        n_vec++;
        if (obs1 !== exp) begin
            n_err++;
            $display("FAIL equal_hold: got %h expected %h", obs1, exp);
        end
    endtask

    task automatic test_lock_lost;
        logic [20:0] exp;
        drive1(1'b1, 1'b0, NE98);
        exp = {1'b1, 1'b0, 1'b0, 1'b1, 8'd0, 8'd1, 1'b1};
        n_vec++;
        if (obs1 !== exp) begin
            n_err++;
            $display("FAIL lock_lost: got %h expected %h", obs1, exp);
        end
        drive1(1'b0, 1'b0, NE98);
        exp = {1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd1, 1'b1};
        n_vec++;
        if (obs1 !== exp) begin
            n_err++;
            $display("FAIL lock_lost_pulse_end: got %h expected %h", obs1, exp);
        end
    endtask

    task automatic test_reacquire_clear;
        logic [20:0] exp;
        for (int k = 1; k <= 2; k++) begin
            drive1(1'b1, 1'b0, EQ97);
            exp = {1'b1, 1'b1, 1'b0, 1'b0, 8'(k), 8'd1, 1'b1};
            n_vec++;
            if (obs1 !== exp) begin
                n_err++;
                $display("FAIL reacquire_%0d: got %h expected %h", k, obs1, exp);
            end
        end
        drive1(1'b1, 1'b1, NE98);
        n_vec++;
        if (obs1 !== 21'd0) begin
            n_err++;
            $display("FAIL clear_wins: got %h expected %h", obs1, 21'd0);
        end
        // From S_IDLE with STABLE_LEN=4 one equal sample must not lock.
        drive1(1'b1, 1'b0, EQ97);
        exp = {1'b1, 1'b1, 1'b0, 1'b0, 8'd1, 8'd0, 1'b0};
        n_vec++;
        if (obs1 !== exp) begin
            n_err++;
            $display("FAIL after_clear: got %h expected %h", obs1, exp);
        end
    endtask

    task automatic test_back_to_back;
        logic [20:0] seq_d   [6];
        logic [20:0] seq_exp [6];
        seq_d[0] = NE98;  seq_exp[0] = {1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 8'd1, 1'b1};
        seq_d[1] = EQ100; seq_exp[1] = {1'b1, 1'b1, 1'b0, 1'b0, 8'd1, 8'd1, 1'b1};
        seq_d[2] = EQ97;  seq_exp[2] = {1'b1, 1'b1, 1'b0, 1'b0, 8'd2, 8'd1, 1'b1};
        seq_d[3] = EQ100; seq_exp[3] = {1'b1, 1'b1, 1'b0, 1'b0, 8'd3, 8'd1, 1'b1};
        seq_d[4] = EQ97;  seq_exp[4] = {1'b1, 1'b1, 1'b1, 1'b0, 8'd4, 8'd1, 1'b1};
        seq_d[5] = NE98;  seq_exp[5] = {1'b1, 1'b0, 1'b0, 1'b1, 8'd0, 8'd2, 1'b1};
        for (int k = 0; k < 6; k++) begin
            drive1(1'b1, 1'b0, seq_d[k]);
            n_vec++;
            if (obs1 !== seq_exp[k]) begin
                n_err++;
                $display("FAIL back_to_back_%0d: got %h expected %h", k, obs1, seq_exp[k]);
            end
        end
        drive1(1'b0, 1'b0, '0);
    endtask

    task automatic test_saturation;
        logic [8:0] exp;
        for (int k = 1; k <= 5; k++) begin
            drive2(1'b1, 1'b0, NE4);
            exp = {1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2'((k > 3) ? 3 : k), 1'b1};
            n_vec++;
            if (obs2 !== exp) begin
                n_err++;
                $display("FAIL mismatch_sat_%0d: got %h expected %h", k, obs2, exp);
            end
        end
        for (int k = 1; k <= 5; k++) begin
            drive2(1'b1, 1'b0, EQ4);
            exp = {1'b1, 1'b1, 1'b1, 1'b0, 2'((k > 3) ? 3 : k), 2'd3, 1'b1};
            n_vec++;
            if (obs2 !== exp) begin
                n_err++;
                $display("FAIL streak_sat_%0d: got %h expected %h", k, obs2, exp);
            end
        end
        drive2(1'b1, 1'b0, NE4);
        exp = {1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 2'd3, 1'b1};
        n_vec++;
        if (obs2 !== exp) begin
            n_err++;
            $display("FAIL sat_lock_lost: got %h expected %h", obs2, exp);
        end
        drive2(1'b0, 1'b1, EQ4);
        n_vec++;
        if (obs2 !== 9'd0) begin
            n_err++;
            $display("FAIL sat_clear: got %h expected %h", obs2, 9'd0);
        end
        drive2(1'b1, 1'b0, EQ4);
        exp = {1'b1, 1'b1, 1'b1, 1'b0, 2'd1, 2'd0, 1'b0};
        n_vec++;
        if (obs2 !== exp) begin
            n_err++;
            $display("FAIL single_lock: got %h expected %h", obs2, exp);
        end
    endtask

`ifdef MATCH_MONITOR_DIFF_EN
    task automatic test_diff;
        drive2(1'b1, 1'b0, {7'd9, 7'd7, 7'd5, 7'd5});
        n_vec++;
        if ({dm2, fd2} !== {4'b1100, 2'd2}) begin
            n_err++;
            $display("FAIL diff_mask_1100: got %h expected %h", {dm2, fd2}, {4'b1100, 2'd2});
        end
        drive2(1'b0, 1'b0, {7'd5, 7'd5, 7'd5, 7'd5});
        n_vec++;
        if ({dm2, fd2} !== {4'b1100, 2'd2}) begin
            n_err++;
            $display("FAIL diff_hold: got %h expected %h", {dm2, fd2}, {4'b1100, 2'd2});
        end
        drive2(1'b1, 1'b0, {7'd5, 7'd5, 7'd5, 7'd5});
        n_vec++;
        if ({dm2, fd2} !== 6'd0) begin
            n_err++;
            $display("FAIL diff_equal: got %h expected %h", {dm2, fd2}, 6'd0);
        end
        drive2(1'b1, 1'b0, {7'd1, 7'd5, 7'd6, 7'd5});
        n_vec++;
        if ({dm2, fd2} !== {4'b1010, 2'd1}) begin
            n_err++;
            $display("FAIL diff_mask_1010: got %h expected %h", {dm2, fd2}, {4'b1010, 2'd1});
        end
        drive2(1'b0, 1'b1, '0);
        n_vec++;
        if ({dm2, fd2} !== 6'd0) begin
            n_err++;
            $display("FAIL diff_clear: got %h expected %h", {dm2, fd2}, 6'd0);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_equal_run();
        test_lock_lost();
        test_reacquire_clear();
        test_back_to_back();
        test_saturation();
`ifdef MATCH_MONITOR_DIFF_EN
        test_diff();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
